fnd_display_controller: RTL and testbench
=========================================

Name: fnd_display_controller

Overview:
Downstream consumer of the dedicated processor's 8-bit outPort; drives the board's 4-digit common-anode seven-segment display. Detects each change in the input value and runs a multi-cycle iterative double-dabble conversion to 3 BCD digits. Time-multiplexes the digits with leading-zero blanking.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency.
SCAN_HZ, 1000, digit-advance rate; TICK_MAX = CLK_FREQ_HZ/SCAN_HZ, integer ≥ 2 required.

Ports:
clk  input  1  system clock, all flops rising-edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
data  input  8  unsigned binary value to display (connects to outPort).
fndCom  output  4  digit enables, active-low; bit0 = ones digit … bit3 = thousands digit.
fndFont  output  8  segments, active-low; bits6:0 = g,f,e,d,c,b,a; bit7 = dp.
bcdOut  output  12  displayed BCD {hundreds, tens, ones}, 4 bits each.
busy  output  1  high while conversion FSM is not IDLE.

Behaviour:
- Reset (reset = 0, asynchronous):
  - FSM = IDLE, lastData = 0, shift/BCD work regs = 0, bcdOut = 0, busy = 0.
  - Tick counter = 0, digitSel = 0.
  - fndCom = 4'b1110, fndFont = 8'hC0 (display "   0").
- Tick generator:
  - Counter runs 0..TICK_MAX-1 and wraps to 0.
  - tick = 1 for exactly one cycle when counter == TICK_MAX-1.
- Digit scan:
  - 2-bit digitSel increments on tick; wraps 3→0.
  - fndCom is a registered one-cold decode of digitSel: 0→1110, 1→1101, 2→1011, 3→0111.
  - fndFont is registered, updated in the same cycle as fndCom, so the two never mismatch.
- Conversion FSM (states IDLE, SHIFT, DONE):
  - IDLE: if data != lastData at an edge, load shiftReg = data, lastData = data, clear BCD work reg, bitCnt = 0, go to SHIFT.
  - SHIFT: one bit per cycle, 8 cycles total. For each BCD nibble ≥ 5, add 3; then shift {bcd, shiftReg} left by 1. bitCnt++; after the 8th shift go to DONE.
  - DONE: bcdOut ← work reg; go to IDLE.
  - Latency: change sampled at edge n → SHIFT at edges n+1..n+8 → bcdOut updated at edge n+9, busy low from n+9.
  - busy = (state != IDLE).
  - data changes during SHIFT/DONE are ignored. On return to IDLE the new value is compared against lastData and triggers a fresh conversion; no value is lost if data stays stable.
  - The maximum value 255 must give hundreds=2, tens=5, ones=5 with no nibble overflow. Work reg is 10 bits minimum.
- Segment select (from bcdOut, not the work reg, so the display never tears):
  - digit0 = ones, always shown.
  - digit1 = tens; blank if hundreds == 0 and tens == 0.
  - digit2 = hundreds; blank if 0.
  - digit3 = always blank.
- Font, active-low:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF.
  - dp is always 1 (off).
- Reset asserted mid-conversion: abort immediately to reset values. After release, a nonzero data input restarts conversion (data != lastData = 0).

Test Plan:
(All scenarios use CLK_FREQ_HZ=1000, SCAN_HZ=250, so TICK_MAX=4.)
1. Hold reset=0 for 3 cycles, data=8'd55 → fndCom=1110, fndFont=C0, bcdOut=0, busy=0. Release reset → busy rises at the next edge; bcdOut=12'h055 exactly 9 edges after busy rises.
2. data=55, steady state, run 16 ticks → digit sequence repeats: (1110,92), (1101,92), (1011,FF), (0111,FF); each digit held for 4 cycles.
3. data=255 → bcdOut=12'h255; scan shows 92,92,A4,FF. data=0 → bcdOut=0; scan shows C0,FF,FF,FF.
4. data=7 then data=100 → tens digit shows C0 (not blanked because hundreds≠0), hundreds shows F9. data=5 → tens blanked (FF).
5. data 10→20 while busy, at the 3rd SHIFT cycle → bcdOut=12'h010 first, then busy re-asserts and bcdOut=12'h020 ends up final.
6. Pulse reset=0 for 1 cycle during SHIFT with data=200 → outputs return to reset values asynchronously; after release, bcdOut=12'h200 exactly 10 edges later.

Source files
------------

// File: rtl/fnd_display_controller.sv
// Seven-segment driver for the processor's 8-bit output port: converts each new value
// to BCD with an iterative double-dabble FSM and scans it onto a 4-digit common-anode display.
module fnd_display_controller #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int SCAN_HZ     = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data,
  output logic [3:0]  fndCom,
  output logic [7:0]  fndFont,
  output logic [11:0] bcdOut,
  output logic        busy
);

  localparam int TICK_MAX = CLK_FREQ_HZ / SCAN_HZ;
  localparam int CNT_W    = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_MAX - 1);

  localparam logic [7:0] FONT_BLANK = 8'hFF;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  last_q, last_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] work_q, work_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [11:0] bcd_out_q, bcd_out_d;
  logic [11:0] work_adj;
  logic [19:0] dabble;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [1:0]       digit_sel;
  logic [3:0]       com_d;
  logic [7:0]       font_d;

  function automatic logic [11:0] dd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [7:0] font7(input logic [3:0] d);
    case (d)
      4'd0:    font7 = 8'hC0;
      4'd1:    font7 = 8'hF9;
      4'd2:    font7 = 8'hA4;
      4'd3:    font7 = 8'hB0;
      4'd4:    font7 = 8'h99;
      4'd5:    font7 = 8'h92;
      4'd6:    font7 = 8'h82;
      4'd7:    font7 = 8'hF8;
      4'd8:    font7 = 8'h80;
      4'd9:    font7 = 8'h90;
      default: font7 = FONT_BLANK;
    endcase
  endfunction

  // Conversion FSM: state and work registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_q    <= '0;
      shift_q   <= '0;
      work_q    <= '0;
      bit_cnt_q <= '0;
      bcd_out_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      shift_q   <= shift_d;
      work_q    <= work_d;
      bit_cnt_q <= bit_cnt_d;
      bcd_out_q <= bcd_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    shift_d   = shift_q;
    work_d    = work_q;
    bit_cnt_d = bit_cnt_q;
    bcd_out_d = bcd_out_q;
    work_adj  = dd_adjust(work_q);
    dabble    = {work_adj, shift_q} << 1;
    case (state_q)
      IDLE: begin
        if (data != last_q) begin
          shift_d   = data;
          last_d    = data;
          work_d    = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        work_d    = dabble[19:8];
        shift_d   = dabble[7:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7)
          state_d = DONE;
      end
      DONE: begin
        bcd_out_d = work_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bcdOut = bcd_out_q;
  assign busy   = (state_q != IDLE);

  // Scan tick and digit select
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt  <= '0;
      digit_sel <= '0;
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      if (tick)
        digit_sel <= digit_sel + 2'd1;
    end
  end

  // Font is taken from the settled bcdOut so a conversion in flight never tears the display
  always_comb begin
    com_d  = 4'b1111;
    font_d = FONT_BLANK;
    case (digit_sel)
      2'd0: begin
        com_d  = 4'b1110;
        font_d = font7(bcd_out_q[3:0]);
      end
      2'd1: begin
        com_d  = 4'b1101;
        if (bcd_out_q[11:8] != 4'd0 || bcd_out_q[7:4] != 4'd0)
          font_d = font7(bcd_out_q[7:4]);
      end
      2'd2: begin
        com_d  = 4'b1011;
        if (bcd_out_q[11:8] != 4'd0)
          font_d = font7(bcd_out_q[11:8]);
      end
      default: begin
        com_d  = 4'b0111;
        font_d = FONT_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fndCom  <= 4'b1110;
      fndFont <= 8'hC0;
    end else begin
      fndCom  <= com_d;
      fndFont <= font_d;
    end
  end

endmodule

// File: tb/tb_fnd_display_controller.sv
// Bench for fnd_display_controller: directed values, scoreboard of expected bcdOut
// consumed on each conversion completion, plus scan pattern and latency checks.
module tb_fnd_display_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data = 8'd0;
  logic [3:0]  fndCom;
  logic [7:0]  fndFont;
  logic [11:0] bcdOut;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int exp_total = 0;
  logic [11:0] exp_q[$];

  fnd_display_controller #(.CLK_FREQ_HZ(1000), .SCAN_HZ(250)) dut (
    .clk(clk), .reset(reset), .data(data),
    .fndCom(fndCom), .fndFont(fndFont), .bcdOut(bcdOut), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push_exp(input logic [11:0] e);
    exp_q.push_back(e);
    exp_total++;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 100) begin
      step();
      n++;
    end
    if (done_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL wait_done: timeout, completions=%0d expected=%0d", done_cnt, target);
    end
  endtask

  // Syncs to the start of the ones-digit window, then checks 16 cycles of scan
  task automatic check_scan(input string name, input logic [7:0] f0, input logic [7:0] f1,
                            input logic [7:0] f2, input logic [7:0] f3);
    logic [3:0] prev_com;
    logic [3:0] exp_com [4];
    logic [7:0] exp_font [4];
    int n = 0;
    bit synced = 0;
    exp_com  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_font = '{f0, f1, f2, f3};
    prev_com = fndCom;
    while (!synced && n < 40) begin
      @(posedge clk);
      #1;
      if (fndCom == 4'b1110 && prev_com == 4'b0111) synced = 1;
      prev_com = fndCom;
      n++;
    end
    check({name, "_sync"}, synced, 1);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      check({name, "_com"}, fndCom, exp_com[k/4]);
      check({name, "_font"}, fndFont, exp_font[k/4]);
    end
  endtask

  // Monitor: a busy falling edge means a finished conversion; compare against scoreboard
  initial begin
    logic prev_busy;
    logic [11:0] e;
    prev_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL bcd_unexpected: got %0h, expected no completion", bcdOut);
          end else begin
            e = exp_q.pop_front();
            check("bcd_out", bcdOut, e);
          end
          done_cnt++;
          done_cyc = cyc;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    int rise_cyc;
    int rel_cyc;
    int first_target;

    // 1: reset values and first conversion latency
    data = 8'd55;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_com", fndCom, 4'b1110);
    check("rst_font", fndFont, 8'hC0);
    check("rst_bcd", bcdOut, 12'h000);
    check("rst_busy", busy, 0);
    push_exp(12'h055);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("busy_rise", busy, 1);
    rise_cyc = cyc;
    wait_done(exp_total);
    check("latency_55", done_cyc - rise_cyc, 9);

    // 2: steady-state scan of 55
    check_scan("scan55", 8'h92, 8'h92, 8'hFF, 8'hFF);

    // 3: max value and zero
    data = 8'd255;
    push_exp(12'h255);
    wait_done(exp_total);
    check_scan("scan255", 8'h92, 8'h92, 8'hA4, 8'hFF);
    data = 8'd0;
    push_exp(12'h000);
    wait_done(exp_total);
    check_scan("scan0", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

    // 4: leading-zero blanking
    data = 8'd7;
    push_exp(12'h007);
    wait_done(exp_total);
    check_scan("scan7", 8'hF8, 8'hFF, 8'hFF, 8'hFF);
    data = 8'd100;
    push_exp(12'h100);
    wait_done(exp_total);
    check_scan("scan100", 8'hC0, 8'hC0, 8'hF9, 8'hFF);
    data = 8'd5;
    push_exp(12'h005);
    wait_done(exp_total);
    check_scan("scan5", 8'h92, 8'hFF, 8'hFF, 8'hFF);

    // 5: change during SHIFT is deferred, then converted
    data = 8'd10;
    push_exp(12'h010);
    first_target = exp_total;
    push_exp(12'h020);
    step();
    step();
    step();
    check("busy_mid", busy, 1);
    data = 8'd20;
    wait_done(first_target);
    step();
    check("busy_reassert", busy, 1);
    wait_done(exp_total);
    check("final_bcd_20", bcdOut, 12'h020);

    // 6: asynchronous reset mid-conversion
    data = 8'd200;
    step();
    step();
    step();
    step();
    check("busy_before_rst", busy, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_com", fndCom, 4'b1110);
    check("arst_font", fndFont, 8'hC0);
    check("arst_bcd", bcdOut, 12'h000);
    check("arst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    rel_cyc = cyc;
    push_exp(12'h200);
    wait_done(exp_total);
    check("latency_200", done_cyc - rel_cyc, 10);
    check_scan("scan200", 8'hC0, 8'hC0, 8'hA4, 8'hFF);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
